rx_window_ctrl: RTL
===================

# rx_window_ctrl

Receive-window controller for the reader's RX front end. After the transmitter signals end of a command, it holds the sampler and its strobe generator in reset for a guard interval, releases them, and waits for the first backscatter activity. It then forwards exactly one frame of strobed samples to the decoder. It also reports completion or timeout back to the reader sequencer.

## Interface
Parameters:
- GUARD_CYC, 64: clk cycles the sampler is held in reset after `start`; minimum 1.
- TIMEOUT_SMP, 1024: sampler strobes allowed in LISTEN without activity before timeout; minimum 1.
- CAP_SMP, 256: samples forwarded per frame, including the triggering sample; minimum 1.

Ports:
- clk, in, 1: single clock, shared with the sampler.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse from the TX sequencer at end of transmit.
- abort, in, 1: level; cancels any window in progress.
- smp_dat, in, 1: synchronised sample from the sampler.
- smp_vld, in, 1: sampler strobe; one-cycle pulse.
- smp_rst, out, 1: synchronous reset to the sampler and strobe generator.
- cap_dat, out, 1: forwarded sample.
- cap_vld, out, 1: forwarded-sample strobe.
- busy, out, 1: high whenever state is not IDLE.
- done, out, 1: one-cycle pulse when a frame has been captured.
- timeout, out, 1: one-cycle pulse when the window expires with no activity.

## Operation
States and transitions:
- IDLE → GUARD on `start`.
- GUARD → LISTEN after GUARD_CYC cycles.
- LISTEN → CAPTURE on the first edge.
- LISTEN → IDLE with a `timeout` pulse after TIMEOUT_SMP strobes with no edge.
- CAPTURE → IDLE with a `done` pulse after CAP_SMP samples have been forwarded.

Sampler control:
- `smp_rst` is high in IDLE and GUARD and low in LISTEN and CAPTURE.
- Releasing `smp_rst` restarts the strobe phase, so sample timing is referenced to the end of the guard interval.

Edge detection:
- A reference bit `prev` is cleared to 0 on entry to LISTEN and updated on every `smp_vld` in LISTEN.
- An edge is `smp_vld && smp_dat != prev`. The sampler's idle output is 0, so a line that is high at release counts as activity.

Counters and forwarding:
- The guard counter is $clog2(GUARD_CYC+1) bits wide.
- One sample counter is shared by LISTEN (timeout) and CAPTURE (length). It is $clog2(max(TIMEOUT_SMP,CAP_SMP)+1) bits wide and cleared on every state entry. It never wraps; the terminal compare is equality.
- The triggering sample is forwarded as sample 0 of the frame. The next CAP_SMP−1 strobes in CAPTURE are forwarded unchanged.
- `smp_vld` in IDLE or GUARD is ignored.

Boundary rules:
- `abort` has priority over all other events: it forces IDLE on the next edge with no `done` or `timeout` pulse, and drops any pending `cap_vld`.
- `start` is ignored while `busy`.
- An edge on the same strobe that would reach TIMEOUT_SMP counts as an edge: go to CAPTURE, no timeout.
- With CAP_SMP = 1, the triggering sample is the whole frame; `done` follows it directly.
- `rst_n` low at any time forces IDLE asynchronously.

## Timing
- Reset values: state IDLE, `smp_rst`=1, `cap_dat`=0, `cap_vld`=0, `busy`=0, `done`=0, `timeout`=0, both counters 0.
- All outputs are registered.
- `start` at cycle t:
  - `busy` goes high at t+1.
  - `smp_rst` stays high through t+GUARD_CYC and goes low at t+GUARD_CYC+1 (first LISTEN cycle).
- `cap_vld`/`cap_dat` follow the corresponding `smp_vld`/`smp_dat` with exactly one cycle of latency.
- `done` is asserted in the same cycle as the last `cap_vld`. `busy` drops on the following cycle.
- `timeout` is asserted one cycle after the TIMEOUT_SMP-th strobe. `busy` drops together with it.
- Earliest re-`start` after `done`/`timeout`: the cycle `busy` reads 0.

## Structure
- Package `rfid_rx_pkg` holds:
  - the state enum (IDLE, GUARD, LISTEN, CAPTURE), 2 bits;
  - default GUARD_CYC, TIMEOUT_SMP and CAP_SMP constants, shared with the sequencer and testbench.
- One natural sub-module, `edge_det`: holds `prev`, takes clear/strobe/data inputs, and outputs a 1-bit edge flag.
- The FSM and counters stay in the top module.

## Test plan
- Nominal frame, GUARD_CYC=4, CAP_SMP=8: `start` at t0; first `smp_dat`=1 with `smp_vld` on the 3rd strobe after release.
  - `smp_rst` low at t0+5.
  - 8 `cap_vld` pulses, the first one carrying 1.
  - `done` coincides with the 8th pulse; `busy` low on the next cycle.
- Timeout, TIMEOUT_SMP=16: `smp_dat` held 0 → `timeout` one cycle after the 16th strobe, no `cap_vld`, `busy` 0 afterwards.
- Edge and timeout on the same strobe: edge on the 16th strobe with TIMEOUT_SMP=16 → CAPTURE entered, no `timeout` pulse.
- Abort in CAPTURE after 3 forwarded samples:
  - IDLE next cycle, no `done`, `smp_rst` high;
  - a subsequent `start` runs a full frame normally.
- `start` asserted during GUARD and during CAPTURE → ignored; exactly one `done` for the frame.
- `rst_n` pulsed low mid-LISTEN, not aligned to `clk` → all outputs at reset values immediately; no pulses after release until a new `start`.

Source files
------------

// File: rtl/rfid_rx_pkg.sv
// Shared definitions for the RFID reader RX window controller.
// Default window sizes are also used by the sequencer and testbench.
package rfid_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GUARD   = 2'd1,
        LISTEN  = 2'd2,
        CAPTURE = 2'd3
    } rx_state_t;

    localparam int unsigned DEF_GUARD_CYC   = 64;
    localparam int unsigned DEF_TIMEOUT_SMP = 1024;
    localparam int unsigned DEF_CAP_SMP     = 256;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rx_window_ctrl_edge_det.sv
// Activity detector: flags a strobed sample that differs from the previous one.
// The reference clears to 0, matching the sampler's idle output level.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic stb,
    input  logic dat,
    output logic edge_flag
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else if (clr) begin
            prev <= 1'b0;
        end else if (stb) begin
            prev <= dat;
        end
    end

    assign edge_flag = stb && (dat != prev);

endmodule

// File: rtl/rx_window_ctrl.sv
// Receive-window controller: guard-resets the sampler after TX, listens for
// backscatter activity, then forwards one frame of strobed samples.
module rx_window_ctrl
    import rfid_rx_pkg::*;
#(
    parameter int unsigned GUARD_CYC   = DEF_GUARD_CYC,
    parameter int unsigned TIMEOUT_SMP = DEF_TIMEOUT_SMP,
    parameter int unsigned CAP_SMP     = DEF_CAP_SMP
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    input  logic smp_dat,
    input  logic smp_vld,
    output logic smp_rst,
    output logic cap_dat,
    output logic cap_vld,
    output logic busy,
    output logic done,
    output logic timeout
);

    localparam int unsigned GW = $clog2(GUARD_CYC + 1);
    localparam int unsigned SW = $clog2(max_u(TIMEOUT_SMP, CAP_SMP) + 1);

    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
    localparam logic [SW-1:0] TMO_LAST   = SW'(TIMEOUT_SMP - 1);
    // The trigger sample is forwarded on LISTEN exit, so CAPTURE counts the remaining CAP_SMP-1.
    localparam logic [SW-1:0] CAP_LAST   = SW'((CAP_SMP >= 2) ? (CAP_SMP - 2) : 0);

    rx_state_t     state;
    logic [GW-1:0] gcnt;
    logic [SW-1:0] scnt;
    logic          edge_flag;

    edge_det u_edge_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state != LISTEN),
        .stb       (smp_vld && (state == LISTEN)),
        .dat       (smp_dat),
        .edge_flag (edge_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gcnt    <= '0;
            scnt    <= '0;
            smp_rst <= 1'b1;
            cap_dat <= 1'b0;
            cap_vld <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            cap_vld <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                gcnt    <= '0;
                scnt    <= '0;
                smp_rst <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= GUARD;
                            gcnt  <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    GUARD: begin
                        if (gcnt == GUARD_LAST) begin
                            state   <= LISTEN;
                            gcnt    <= '0;
                            scnt    <= '0;
                            smp_rst <= 1'b0;
                        end else begin
                            gcnt <= gcnt + 1'b1;
                        end
                    end
                    LISTEN: begin
                        if (smp_vld) begin
                            // An edge wins over a simultaneous timeout.
                            if (edge_flag) begin
                                state   <= CAPTURE;
                                scnt    <= '0;
                                cap_vld <= 1'b1;
                                cap_dat <= smp_dat;
                                if (CAP_SMP == 1) begin
                                    done <= 1'b1;
                                end
                            end else if (scnt == TMO_LAST) begin
                                state   <= IDLE;
                                scnt    <= '0;
                                timeout <= 1'b1;
                                busy    <= 1'b0;
                                smp_rst <= 1'b1;
                            end else begin
                                scnt <= scnt + 1'b1;
                            end
                        end
                    end
                    CAPTURE: begin
                        // Stay one cycle past the last sample so busy drops after done.
                        if (done) begin
                            state   <= IDLE;
                            scnt    <= '0;
                            busy    <= 1'b0;
                            smp_rst <= 1'b1;
                        end else if (smp_vld) begin
                            cap_vld <= 1'b1;
                            cap_dat <= smp_dat;
                            if (scnt == CAP_LAST) begin
                                done <= 1'b1;
                            end else begin
                                scnt <= scnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
